// File: rtl/dnn_feed_sequencer.sv
// dnn_feed_sequencer
//
// Feeds training cases into the DNN input layer. Wide FIFO words are unpacked
// into AW-bit activation slices, lowest slice first, and each slice is paired
// with an ANS_W-bit slice of the case's ideal output. After F = CPC-PIPE feed
// cycles the block inserts PIPE bubble cycles. Cases and epochs are counted
// here. The block stalls while the FIFO is empty.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   start        one-cycle pulse in IDLE that begins a run
//   fifo_dout    FIFO head word (first-word-fall-through)
//   fifo_empty   FIFO empty flag
//   fifo_rd_en   pops the FIFO head word
//   mem_addr     ideal-output memory address (registered)
//   ans_mem      ideal-output memory data, valid one clock after mem_addr
//   act_o        activation slice
//   ans_o        ideal-output slice
//   feed_valid   act_o/ans_o are valid this cycle
//   block_start  high on feed index 0 of each case
//   tc_idx       current training case
//   epoch        current epoch
//   check_o      current case is one of the last CHECKLAST cases of the run
//   stall_cnt    saturating count of cycles stalled on an empty FIFO
//   done         run complete
module dnn_feed_sequencer #(
    parameter int DW        = 128,
    parameter int AW        = 128,
    parameter int CPC       = 66,
    parameter int PIPE      = 2,
    parameter int TC        = 12544,
    parameter int EPOCHS    = 10,
    parameter int LOOP      = 0,
    parameter int CHECKLAST = 1000,
    parameter int NOUT      = 10,
    parameter int NL        = 64,
    parameter int ANS_W     = 1,
    localparam int TW       = (TC > 1) ? $clog2(TC) : 1,
    localparam int EW       = (EPOCHS > 1) ? $clog2(EPOCHS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    output logic [TW-1:0] mem_addr,
    input  logic [NOUT-1:0] ans_mem,
    output logic [AW-1:0] act_o,
    output logic [ANS_W-1:0] ans_o,
    output logic          feed_valid,
    output logic          block_start,
    output logic [TW-1:0] tc_idx,
    output logic [EW-1:0] epoch,
    output logic          check_o,
    output logic [31:0]   stall_cnt,
    output logic          done
);

    localparam int F      = CPC - PIPE;
    localparam int R      = DW / AW;
    localparam int NA     = NL / ANS_W;
    localparam int KW     = (F > 1) ? $clog2(F) : 1;
    localparam int RW     = (R > 1) ? $clog2(R) : 1;
    localparam int AIW    = (NA > 1) ? $clog2(NA) : 1;
    localparam int PW     = (PIPE > 1) ? $clog2(PIPE) : 1;
    localparam int THRESH = EPOCHS * TC - CHECKLAST;

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

    state_t         state;
    state_t         state_nx;
    logic [KW-1:0]  k;
    logic [RW-1:0]  r;
    logic [AIW-1:0] a;
    logic [PW-1:0]  f;

    logic           feeding;
    logic           last_k;
    logic           last_r;
    logic           last_a;
    logic           last_f;
    logic           last_tc;
    logic           last_ep;
    logic           run_end;
    logic [TW-1:0]  next_tc;
    logic [NL-1:0]  ans_tc;
    logic [31:0]    lin;

    // r and a track k mod (DW/AW) and k mod (NL/ANS_W) as separate counters
    // so no modulo by a non-power-of-two constant is needed.
    always_comb begin
        feeding = (state == FEED) && !fifo_empty;
        last_k  = (k == KW'(F - 1));
        last_r  = (r == RW'(R - 1));
        last_a  = (a == AIW'(NA - 1));
        last_f  = (f == PW'(PIPE - 1));
        last_tc = (tc_idx == TW'(TC - 1));
        last_ep = (epoch == EW'(EPOCHS - 1));
        run_end = (LOOP == 0) && last_tc && last_ep;
        next_tc = last_tc ? '0 : tc_idx + 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FEED;
            FEED:    if (feeding && last_k) state_nx = FLUSH;
            FLUSH:   if (last_f) state_nx = run_end ? DONE : FEED;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Feed outputs are combinational. A cycle with reset high issues neither
    // a pop nor a valid slice, so no FIFO word is lost across a reset.
    always_comb begin
        ans_tc             = '0;
        ans_tc[NOUT-1:0]   = ans_mem;
        feed_valid         = feeding && !reset;
        fifo_rd_en         = feed_valid && (last_r || last_k);
        block_start        = feed_valid && (k == '0);
        act_o              = '0;
        ans_o              = '0;
        if (feed_valid) begin
            act_o = fifo_dout[r*AW +: AW];
            ans_o = ans_tc[a*ANS_W +: ANS_W];
        end
        done = (state == DONE);
    end

    // Position in the run as a linear case number; check_o is only
    // meaningful while a case is in progress and never in loop mode.
    always_comb begin
        lin     = 32'(epoch) * 32'(TC) + 32'(tc_idx);
        check_o = 1'b0;
        if (LOOP == 0 && (state == FEED || state == FLUSH))
            check_o = (THRESH <= 0) || (lin >= 32'(THRESH));
    end

    // mem_addr is loaded with the next case on entry to FLUSH so the memory
    // read completes during the bubbles. Counters hold at the final case when
    // the run ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            r         <= '0;
            a         <= '0;
            f         <= '0;
            mem_addr  <= '0;
            tc_idx    <= '0;
            epoch     <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == FEED && fifo_empty && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (feeding) begin
                if (last_k) begin
                    k        <= '0;
                    r        <= '0;
                    a        <= '0;
                    mem_addr <= next_tc;
                end else begin
                    k <= k + 1'b1;
                    r <= last_r ? '0 : r + 1'b1;
                    a <= last_a ? '0 : a + 1'b1;
                end
            end
            if (state == FLUSH) begin
                if (last_f) begin
                    f <= '0;
                    if (!run_end) begin
                        tc_idx <= next_tc;
                        if (last_tc)
                            epoch <= last_ep ? '0 : epoch + 1'b1;
                    end
                end else begin
                    f <= f + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dnn_feed_sequencer.sv
// Testbench for dnn_feed_sequencer with small parameters
// (DW=16, AW=8, CPC=6, PIPE=2, TC=3, EPOCHS=2, NOUT=3, NL=4, ANS_W=1,
// CHECKLAST=2). dut0 runs with LOOP=0 and dut1 with LOOP=1. Both share their
// inputs, so they stay in lock-step until dut0 finishes its run.
module tb_dnn_feed_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_clear;
    int          widx;

    logic [2:0]  mem [4];
    logic [2:0]  ans_mem0;
    logic [2:0]  ans_mem1;

    logic        rd0, fv0, bs0, chk0, done0;
    logic [1:0]  addr0, tc0;
    logic [0:0]  ep0;
    logic [7:0]  act0;
    logic [0:0]  ans0;
    logic [31:0] stall0;

    logic        rd1, fv1, bs1, chk1, done1;
    logic [1:0]  addr1, tc1;
    logic [0:0]  ep1;
    logic [7:0]  act1;
    logic [0:0]  ans1;
    logic [31:0] stall1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        empty;
        logic        fv;
        logic [7:0]  act;
        logic        ans;
        logic        rd;
        logic        bs;
        logic [1:0]  addr;
        logic [1:0]  tc;
        logic [31:0] stall;
    } vec_t;

    vec_t vecs [15];

    always #5 clk = ~clk;

    dnn_feed_sequencer #(
        .DW(16), .AW(8), .CPC(6), .PIPE(2), .TC(3), .EPOCHS(2), .LOOP(0),
        .CHECKLAST(2), .NOUT(3), .NL(4), .ANS_W(1)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(rd0),
        .mem_addr(addr0), .ans_mem(ans_mem0),
        .act_o(act0), .ans_o(ans0), .feed_valid(fv0), .block_start(bs0),
        .tc_idx(tc0), .epoch(ep0), .check_o(chk0), .stall_cnt(stall0),
        .done(done0)
    );

    dnn_feed_sequencer #(
        .DW(16), .AW(8), .CPC(6), .PIPE(2), .TC(3), .EPOCHS(2), .LOOP(1),
        .CHECKLAST(2), .NOUT(3), .NL(4), .ANS_W(1)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(rd1),
        .mem_addr(addr1), .ans_mem(ans_mem1),
        .act_o(act1), .ans_o(ans1), .feed_valid(fv1), .block_start(bs1),
        .tc_idx(tc1), .epoch(ep1), .check_o(chk1), .stall_cnt(stall1),
        .done(done1)
    );

    // Infinite FIFO stream: word n = {A1+34n, B2+34n} bytewise, so
    // 0xA1B2, 0xC3D4, 0xE5F6, 0x0718, ...
    function automatic logic [15:0] word_of(input int n);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'hB2 + 8'(n * 34);
        hi = 8'hA1 + 8'(n * 34);
        return {hi, lo};
    endfunction

    assign fifo_dout = word_of(widx);

    always @(posedge clk) begin
        if (fifo_clear)
            widx <= 0;
        else if (rd0)
            widx <= widx + 1;
    end

    always @(posedge clk) begin
        ans_mem0 <= mem[addr0];
        ans_mem1 <= mem[addr1];
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        fifo_empty = v.empty;
    endtask

    task automatic check_reset_values();
        check_output("rst fifo_rd_en", 32'(rd0), 0);
        check_output("rst feed_valid", 32'(fv0), 0);
        check_output("rst block_start", 32'(bs0), 0);
        check_output("rst act_o", 32'(act0), 0);
        check_output("rst ans_o", 32'(ans0), 0);
        check_output("rst mem_addr", 32'(addr0), 0);
        check_output("rst tc_idx", 32'(tc0), 0);
        check_output("rst epoch", 32'(ep0), 0);
        check_output("rst check_o", 32'(chk0), 0);
        check_output("rst stall_cnt", stall0, 0);
        check_output("rst done", 32'(done0), 0);
        check_output("rst loop tc_idx", 32'(tc1), 0);
    endtask

    task automatic wait_block_start(output int n);
        logic found;
        found = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            @(negedge clk);
            n++;
            if (bs0) found = 1'b1;
        end
        if (!found) check_output("block_start timeout", 0, 1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int saved;

        mem[0] = 3'b101;
        mem[1] = 3'b011;
        mem[2] = 3'b110;
        mem[3] = 3'b000;

        //          empty fv  act    ans  rd   bs   addr tc   stall
        vecs[0]  = '{1'b0, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'hD4, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0};
        vecs[3]  = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'd0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 32'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 32'd0};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 32'd0};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 32'd1};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 32'd2};
        vecs[9]  = '{1'b0, 1'b1, 8'hF6, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 32'd3};
        vecs[10] = '{1'b0, 1'b1, 8'hE5, 1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 32'd3};
        vecs[11] = '{1'b0, 1'b1, 8'h18, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 32'd3};
        vecs[12] = '{1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 32'd3};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 32'd3};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 32'd3};

        reset      = 1'b1;
        start      = 1'b0;
        fifo_empty = 1'b0;
        fifo_clear = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        fifo_clear = 1'b0;
        @(negedge clk);
        check_reset_values();

        // Case 0 straight through, then case 1 with three empty-FIFO cycles.
        pulse_start();
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output($sformatf("v%0d feed_valid", i), 32'(fv0), 32'(vecs[i].fv));
            check_output($sformatf("v%0d act_o", i), 32'(act0), 32'(vecs[i].act));
            check_output($sformatf("v%0d ans_o", i), 32'(ans0), 32'(vecs[i].ans));
            check_output($sformatf("v%0d fifo_rd_en", i), 32'(rd0), 32'(vecs[i].rd));
            check_output($sformatf("v%0d block_start", i), 32'(bs0), 32'(vecs[i].bs));
            check_output($sformatf("v%0d mem_addr", i), 32'(addr0), 32'(vecs[i].addr));
            check_output($sformatf("v%0d tc_idx", i), 32'(tc0), 32'(vecs[i].tc));
            check_output($sformatf("v%0d stall_cnt", i), stall0, vecs[i].stall);
            check_output($sformatf("v%0d check_o", i), 32'(chk0), 0);
            @(posedge clk);
            #1;
        end

        // Remaining cases: case 2 follows the stalled 9-clock case 1 at once;
        // later cases start every 6 clocks.
        for (int c = 2; c < 6; c++) begin
            wait_block_start(n);
            check_output($sformatf("case%0d period", c), 32'(n), (c == 2) ? 32'd1 : 32'd6);
            check_output($sformatf("case%0d tc_idx", c), 32'(tc0), 32'(c % 3));
            check_output($sformatf("case%0d epoch", c), 32'(ep0), 32'(c / 3));
            check_output($sformatf("case%0d check_o", c), 32'(chk0), (c >= 4) ? 32'd1 : 32'd0);
            check_output($sformatf("case%0d loop epoch", c), 32'(ep1), 32'(c / 3));
            check_output($sformatf("case%0d loop check_o", c), 32'(chk1), 0);
        end

        repeat (6) @(negedge clk);
        check_output("done", 32'(done0), 1);
        check_output("done feed_valid", 32'(fv0), 0);
        check_output("done fifo_rd_en", 32'(rd0), 0);
        check_output("done act_o", 32'(act0), 0);
        check_output("done stall_cnt", stall0, 3);
        check_output("loop block_start", 32'(bs1), 1);
        check_output("loop done", 32'(done1), 0);
        check_output("loop tc_idx", 32'(tc1), 0);
        check_output("loop epoch", 32'(ep1), 0);
        check_output("loop check_o", 32'(chk1), 0);

        pulse_start();
        @(negedge clk);
        check_output("start ignored done", 32'(done0), 1);
        check_output("start ignored feed_valid", 32'(fv0), 0);

        // Fresh run for the mid-run reset sequences.
        @(posedge clk); #1 reset = 1'b1;
        fifo_clear = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        fifo_clear = 1'b0;
        @(negedge clk);
        check_reset_values();

        pulse_start();
        @(negedge clk);
        check_output("restart block_start", 32'(bs0), 1);
        check_output("restart act_o", 32'(act0), 32'h B2);
        check_output("restart tc_idx", 32'(tc0), 0);
        wait_block_start(n);
        check_output("mid case1 period", 32'(n), 6);
        check_output("mid case1 tc_idx", 32'(tc0), 1);
        repeat (2) @(negedge clk);
        check_output("mid k2 act_o", 32'(act0), 32'h18);
        reset = 1'b1;
        #1;
        check_output("mid k2 fifo_rd_en", 32'(rd0), 0);
        saved = widx;
        @(posedge clk); #1 reset = 1'b0;
        check_output("mid k2 no pop", 32'(widx), 32'(saved));
        @(negedge clk);
        check_reset_values();

        pulse_start();
        @(negedge clk);
        check_output("resume block_start", 32'(bs0), 1);
        check_output("resume tc_idx", 32'(tc0), 0);
        check_output("resume act_o", 32'(act0), 32'h18);

        // Reset landing on a pop cycle (k=3) must suppress that pop.
        repeat (3) @(negedge clk);
        check_output("k3 pop before reset", 32'(rd0), 1);
        reset = 1'b1;
        #1;
        check_output("k3 fifo_rd_en under reset", 32'(rd0), 0);
        saved = widx;
        @(posedge clk); #1 reset = 1'b0;
        check_output("k3 no pop", 32'(widx), 32'(saved));
        @(negedge clk);
        check_reset_values();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
